// File: rtl/snd_seq_ctrl_pkg.sv
// rtl/snd_seq_ctrl_pkg.sv - shared state encoding and sound descriptor table for the sequencer
package snd_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_FETCH,
    ST_END
  } state_t;

  // Descriptor table: LUT start address and sample count per sound id.
  function automatic int snd_base(input int id);
    case (id)
      0:       return 'h040;
      1:       return 'h100;
      2:       return 'h3FE;
      3:       return 'h200;
      default: return 0;
    endcase
  endfunction

  function automatic int snd_len(input int id);
    case (id)
      0:       return 3;
      1:       return 4;
      2:       return 4;
      3:       return 0;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/snd_tick_gen.sv
// rtl/snd_tick_gen.sv - sample-rate divider with synchronous clear and 1-cycle tick
module snd_tick_gen #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A clear in cycle t places the first tick DIV cycles later.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/snd_seq_ctrl.sv
// rtl/snd_seq_ctrl.sv - fixed-priority play arbiter and LUT sample sequencer
module snd_seq_ctrl
  import snd_seq_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SND_W     = 2,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 8000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SND_W-1:0] req_snd,
  input  logic                   stop,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done,
  output logic                   lut_rd_en,
  output logic [ADDR_W-1:0]      lut_addr,
  input  logic [DATA_W-1:0]      lut_data,
  output logic [DATA_W-1:0]      sample_out,
  output logic                   sample_vld
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   sample_q;
  logic                tick;
  logic                any_req;
  logic                accept;
  logic [N_REQ-1:0]    pick;
  logic [SND_W-1:0]    pick_snd;

  // Lowest index wins.
  always_comb begin
    any_req  = 1'b0;
    pick     = '0;
    pick_snd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && !any_req) begin
        any_req  = 1'b1;
        pick[i]  = 1'b1;
        pick_snd = req_snd[i*SND_W +: SND_W];
      end
    end
  end

  assign accept = (state == ST_IDLE) && any_req;

  snd_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_nxt  = state;
    grant      = '0;
    lut_rd_en  = 1'b0;
    lut_addr   = '0;
    sample_vld = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant     = pick;
          state_nxt = (snd_len(int'(pick_snd)) == 0) ? ST_END : ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          lut_rd_en = 1'b1;
          lut_addr  = base_q + cnt_q[ADDR_W-1:0];
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else begin
          sample_vld = 1'b1;
          state_nxt  = (cnt_q == len_q - LEN_W'(1)) ? ST_END : ST_PLAY;
        end
      end
      ST_END: begin
        done      = !stop;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  // LUT data is presented in the fetch cycle itself, then held in sample_q.
  assign sample_out = sample_vld ? lut_data : sample_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sample_q <= MID;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q <= ADDR_W'(snd_base(int'(pick_snd)));
        len_q  <= LEN_W'(snd_len(int'(pick_snd)));
        cnt_q  <= '0;
      end
      if (sample_vld) begin
        sample_q <= lut_data;
        cnt_q    <= cnt_q + LEN_W'(1);
      end
      if (busy && (stop || state == ST_END)) begin
        sample_q <= MID;
      end
    end
  end

endmodule

// File: tb/tb_snd_seq_ctrl.sv
// tb/tb_snd_seq_ctrl.sv - randomized self-checking bench for snd_seq_ctrl against an event-timeline model
module tb_snd_seq_ctrl;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] req_snd = '0;
  logic       stop = 1'b0;
  logic [3:0] grant;
  logic       busy, done, lut_rd_en, sample_vld;
  logic [9:0] lut_addr;
  logic [7:0] lut_data = '0;
  logic [7:0] sample_out;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  int         gnt_cyc[$];
  logic [3:0] gnt_val[$];
  int         rd_cyc[$];
  int         rd_addr[$];
  int         smp_cyc[$];
  int         smp_val[$];
  int         done_cyc[$];

  snd_seq_ctrl #(
    .N_REQ(4), .SND_W(2), .ADDR_W(10), .DATA_W(8),
    .CLK_HZ(64000), .SAMPLE_HZ(8000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_snd(req_snd), .stop(stop),
    .grant(grant), .busy(busy), .done(done), .lut_rd_en(lut_rd_en),
    .lut_addr(lut_addr), .lut_data(lut_data), .sample_out(sample_out),
    .sample_vld(sample_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LUT preloaded with data = addr[7:0], one-cycle read latency
  always @(posedge clk) if (lut_rd_en) lut_data <= lut_addr[7:0];

  always @(negedge clk) begin
    if (grant != 0) begin gnt_cyc.push_back(cyc); gnt_val.push_back(grant); end
    if (lut_rd_en === 1'b1) begin rd_cyc.push_back(cyc); rd_addr.push_back(int'(lut_addr)); end
    if (sample_vld === 1'b1) begin smp_cyc.push_back(cyc); smp_val.push_back(int'(sample_out)); end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  function automatic int tb_base(input int id);
    case (id) 0: return 'h040; 1: return 'h100; 2: return 'h3FE; default: return 'h200; endcase
  endfunction

  function automatic int tb_len(input int id);
    case (id) 0: return 3; 1: return 4; 2: return 4; default: return 0; endcase
  endfunction

  task automatic clear_logs();
    gnt_cyc.delete(); gnt_val.delete(); rd_cyc.delete(); rd_addr.delete();
    smp_cyc.delete(); smp_val.delete(); done_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (grant !== 4'b0) $display("FAIL reset_grant got %b want 0000", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (lut_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", lut_rd_en); else n_pass++;
    n_total++; if (lut_addr !== 10'h0) $display("FAIL reset_addr got %h want 000", lut_addr); else n_pass++;
    n_total++; if (sample_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", sample_vld); else n_pass++;
    n_total++; if (sample_out !== 8'h80) $display("FAIL reset_sample got %h want 80", sample_out); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Directed cases first (basic, wrap-around, zero length), then random request mixes.
  task automatic test_play();
    for (int t = 0; t < 12; t++) begin
      logic [3:0] r;
      logic [7:0] s;
      int idx, id, b, l, g, w, exp_done;
      case (t)
        0: begin r = 4'b0010; s = 8'h04; end
        1: begin r = 4'b0100; s = 8'h20; end
        2: begin r = 4'b0001; s = 8'h03; end
        default: begin r = 4'($urandom_range(1, 15)); s = 8'($urandom); end
      endcase
      idx = 0;
      while (idx < 3 && !r[idx]) idx++;
      id = int'(s[idx*2 +: 2]);
      b = tb_base(id);
      l = tb_len(id);
      clear_logs();
      @(posedge clk); #1;
      req = r; req_snd = s;
      w = 0;
      while (w < 5 && gnt_cyc.size() == 0) begin @(posedge clk); w++; end
      #1 req = '0;
      w = 0;
      while (w < 400 && busy !== 1'b0) begin @(posedge clk); #1; w++; end
      n_total++; if (busy !== 1'b0) $display("FAIL play%0d_timeout busy=%b want 0", t, busy); else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (gnt_cyc.size() != 1) $display("FAIL play%0d_grant_count got %0d want 1", t, gnt_cyc.size()); else n_pass++;
      g = (gnt_cyc.size() > 0) ? gnt_cyc[0] : 0;
      if (gnt_val.size() > 0) begin
        n_total++; if (gnt_val[0] !== 4'(1 << idx)) $display("FAIL play%0d_grant got %b want %b", t, gnt_val[0], 4'(1 << idx)); else n_pass++;
      end
      n_total++; if (rd_addr.size() != l) $display("FAIL play%0d_reads got %0d want %0d", t, rd_addr.size(), l); else n_pass++;
      n_total++; if (smp_val.size() != l) $display("FAIL play%0d_samples got %0d want %0d", t, smp_val.size(), l); else n_pass++;
      for (int k = 0; k < l && k < rd_addr.size(); k++) begin
        n_total++; if (rd_addr[k] != (b + k) % 1024) $display("FAIL play%0d_addr%0d got %h want %h", t, k, rd_addr[k], (b + k) % 1024); else n_pass++;
        n_total++; if (rd_cyc[k] != g + DIV * (k + 1)) $display("FAIL play%0d_rd_time%0d got %0d want %0d", t, k, rd_cyc[k] - g, DIV * (k + 1)); else n_pass++;
      end
      for (int k = 0; k < l && k < smp_val.size(); k++) begin
        n_total++; if (smp_val[k] != (b + k) % 256) $display("FAIL play%0d_sample%0d got %h want %h", t, k, smp_val[k], (b + k) % 256); else n_pass++;
        n_total++; if (smp_cyc[k] != g + DIV * (k + 1) + 1) $display("FAIL play%0d_vld_time%0d got %0d want %0d", t, k, smp_cyc[k] - g, DIV * (k + 1) + 1); else n_pass++;
      end
      exp_done = (l == 0) ? g + 1 : g + DIV * l + 2;
      n_total++; if (done_cyc.size() != 1) $display("FAIL play%0d_done_count got %0d want 1", t, done_cyc.size()); else n_pass++;
      if (done_cyc.size() > 0) begin
        n_total++; if (done_cyc[0] != exp_done) $display("FAIL play%0d_done_time got %0d want %0d", t, done_cyc[0] - g, exp_done - g); else n_pass++;
      end
      n_total++; if (sample_out !== 8'h80) $display("FAIL play%0d_idle_sample got %h want 80", t, sample_out); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int w;
    clear_logs();
    @(posedge clk); #1;
    req = 4'b1010; req_snd = 8'h84;
    w = 0;
    while (w < 5 && gnt_cyc.size() == 0) begin @(posedge clk); w++; end
    #1 req = 4'b1000;
    w = 0;
    while (w < 100 && gnt_cyc.size() < 2) begin @(posedge clk); w++; end
    #1 req = '0;
    w = 0;
    while (w < 100 && busy !== 1'b0) begin @(posedge clk); #1; w++; end
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (gnt_cyc.size() != 2 || done_cyc.size() != 2) $display("FAIL b2b_counts got grants=%0d dones=%0d want 2/2", gnt_cyc.size(), done_cyc.size()); else n_pass++;
    if (gnt_cyc.size() == 2 && done_cyc.size() == 2) begin
      n_total++; if (gnt_val[0] !== 4'b0010) $display("FAIL b2b_first_grant got %b want 0010", gnt_val[0]); else n_pass++;
      n_total++; if (gnt_val[1] !== 4'b1000) $display("FAIL b2b_second_grant got %b want 1000", gnt_val[1]); else n_pass++;
      n_total++; if (done_cyc[0] != gnt_cyc[0] + 4 * DIV + 2) $display("FAIL b2b_done1 got %0d want %0d", done_cyc[0] - gnt_cyc[0], 4 * DIV + 2); else n_pass++;
      n_total++; if (gnt_cyc[1] != done_cyc[0] + 1) $display("FAIL b2b_regrant got %0d want %0d", gnt_cyc[1] - done_cyc[0], 1); else n_pass++;
      n_total++; if (done_cyc[1] != gnt_cyc[1] + 4 * DIV + 2) $display("FAIL b2b_done2 got %0d want %0d", done_cyc[1] - gnt_cyc[1], 4 * DIV + 2); else n_pass++;
    end
    if (rd_addr.size() == 8) begin
      n_total++; if (rd_addr[4] != 'h3FE || rd_addr[6] != 'h000 || rd_addr[7] != 'h001) $display("FAIL b2b_wrap got %h %h %h want 3fe 000 001", rd_addr[4], rd_addr[6], rd_addr[7]); else n_pass++;
    end else begin
      n_total++; $display("FAIL b2b_reads got %0d want 8", rd_addr.size());
    end
  endtask

  task automatic test_stop();
    int w;
    clear_logs();
    @(posedge clk); #1;
    req = 4'b0010; req_snd = 8'h04;
    w = 0;
    while (w < 5 && gnt_cyc.size() == 0) begin @(posedge clk); w++; end
    #1 req = '0;
    w = 0;
    while (w < 100 && smp_val.size() < 2) begin @(posedge clk); w++; end
    #1 stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL stop_busy got %b want 0", busy); else n_pass++;
    n_total++; if (sample_out !== 8'h80) $display("FAIL stop_sample got %h want 80", sample_out); else n_pass++;
    repeat (40) @(posedge clk);
    #1;
    n_total++; if (done_cyc.size() != 0) $display("FAIL stop_done got %0d pulses want 0", done_cyc.size()); else n_pass++;
    n_total++; if (smp_val.size() != 2) $display("FAIL stop_samples got %0d want 2", smp_val.size()); else n_pass++;
    n_total++; if (rd_addr.size() != 2) $display("FAIL stop_reads got %0d want 2", rd_addr.size()); else n_pass++;
  endtask

  task automatic test_stop_idle();
    int w;
    clear_logs();
    @(posedge clk); #1;
    req = 4'b0100; req_snd = 8'h30; stop = 1'b1;
    w = 0;
    while (w < 5 && gnt_cyc.size() == 0) begin @(posedge clk); w++; end
    #1 req = '0; stop = 1'b0;
    w = 0;
    while (w < 20 && busy !== 1'b0) begin @(posedge clk); #1; w++; end
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (gnt_val.size() != 1 || gnt_val[0] !== 4'b0100) $display("FAIL stop_idle_grant got count=%0d want one 0100", gnt_val.size()); else n_pass++;
    n_total++; if (done_cyc.size() != 1 || gnt_cyc.size() != 1 || done_cyc[0] != gnt_cyc[0] + 1) $display("FAIL stop_idle_len0_done got count=%0d want 1 at grant+1", done_cyc.size()); else n_pass++;
    n_total++; if (rd_addr.size() != 0) $display("FAIL stop_idle_len0_reads got %0d want 0", rd_addr.size()); else n_pass++;
  endtask

  task automatic test_reset_fetch();
    int w;
    clear_logs();
    @(posedge clk); #1;
    req = 4'b0010; req_snd = 8'h04;
    w = 0;
    while (w < 5 && gnt_cyc.size() == 0) begin @(posedge clk); w++; end
    #1 req = '0;
    w = 0;
    while (w < 100 && rd_addr.size() == 0) begin @(posedge clk); w++; end
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || grant !== 4'b0) $display("FAIL rstf_ctrl got busy=%b done=%b grant=%b want 0 0 0000", busy, done, grant); else n_pass++;
    n_total++; if (lut_rd_en !== 1'b0 || lut_addr !== 10'h0) $display("FAIL rstf_lut got en=%b addr=%h want 0 000", lut_rd_en, lut_addr); else n_pass++;
    n_total++; if (sample_vld !== 1'b0 || sample_out !== 8'h80) $display("FAIL rstf_sample got vld=%b out=%h want 0 80", sample_vld, sample_out); else n_pass++;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_total++; if (smp_val.size() > 1 || done_cyc.size() != 0 || busy !== 1'b0) $display("FAIL rstf_after got samples=%0d dones=%0d busy=%b want <=1 0 0", smp_val.size(), done_cyc.size(), busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_play();
    test_back_to_back();
    test_stop();
    test_stop_idle();
    test_reset_fetch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
